tt_um_jleugeri_ttt_event_fifo: RTL

//  Output event buffer directly downstream of the TTT main core. Captures each start/stop token event
//  (processor id + startstop code) that the core reports during its output-scan stage.

---
 rtl/tt_um_jleugeri_ttt_event_fifo.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/tt_um_jleugeri_ttt_event_fifo.sv
// Output event buffer for the TTT core.
// Each start/stop event is stamped with the current time step and queued.
// The host drains the queue over a first-word-fall-through pop handshake.
module tt_um_jleugeri_ttt_event_fifo #(
  parameter  int NUM_PROCESSORS = 10,
  parameter  int FIFO_DEPTH     = 8,
  parameter  int TIME_BITS      = 8,
  parameter  int DROP_BITS      = 4,
  localparam int PID_BITS       = $clog2(NUM_PROCESSORS),
  localparam int PTR_BITS       = $clog2(FIFO_DEPTH),
  localparam int DATA_BITS      = TIME_BITS + PID_BITS + 2
) (
  input  logic                 clock_fast,
  input  logic                 reset,
  input  logic                 event_valid_in,
  input  logic [PID_BITS-1:0]  processor_id_in,
  input  logic [1:0]           token_startstop_in,
  input  logic [1:0]           stage_in,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic [PTR_BITS:0]    fifo_count,
  output logic                 overflow,
  output logic [DROP_BITS-1:0] dropped_count,
  input  logic                 clear_overflow,
  output logic [TIME_BITS-1:0] time_step
);

  localparam logic [PTR_BITS:0]    FULL_COUNT = (PTR_BITS + 1)'(FIFO_DEPTH);
  localparam logic [DROP_BITS-1:0] DROP_MAX   = '1;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_BITS-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_BITS-1:0]  rdPtr_q, rdPtr_d;
  logic [PTR_BITS:0]    count_q, count_d;
  logic                 dataValid_q;
  logic                 overflow_q, overflow_d;
  logic [DROP_BITS-1:0] dropped_q, dropped_d;
  logic [TIME_BITS-1:0] timeStep_q, timeStep_d;
  logic [1:0]           stagePrev_q;

  logic pushReq;
  logic popEff;
  logic isFull;
  logic pushAcc;
  logic dropEvt;
  logic [DATA_BITS-1:0] pushWord;

  // Classify this cycle's push/pop requests; a full FIFO still accepts a push if a pop frees a slot.
  always_comb begin
    pushReq  = event_valid_in && ((token_startstop_in == 2'b10) || (token_startstop_in == 2'b01));
    popEff   = pop && (count_q != '0);
    isFull   = (count_q == FULL_COUNT);
    pushAcc  = pushReq && (!isFull || popEff);
    dropEvt  = pushReq && isFull && !popEff;
    pushWord = {timeStep_q, processor_id_in, token_startstop_in};
  end

  // Next pointer and occupancy values from the accepted push/pop pair.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushAcc) begin
      wrPtr_d = wrPtr_q + PTR_BITS'(1);
    end
    if (popEff) begin
      rdPtr_d = rdPtr_q + PTR_BITS'(1);
    end
    case ({pushAcc, popEff})
      2'b10:   count_d = count_q + (PTR_BITS + 1)'(1);
      2'b01:   count_d = count_q - (PTR_BITS + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky overflow and saturating drop counter; a clear in the same cycle beats a drop.
  always_comb begin
    overflow_d = overflow_q;
    dropped_d  = dropped_q;
    if (clear_overflow) begin
      overflow_d = 1'b0;
      dropped_d  = '0;
    end else if (dropEvt) begin
      overflow_d = 1'b1;
      if (dropped_q != DROP_MAX) begin
        dropped_d = dropped_q + DROP_BITS'(1);
      end
    end
  end

  // The time step advances when the core leaves its output-scan stage (10 -> 00).
  always_comb begin
    timeStep_d = timeStep_q;
    if ((stagePrev_q == 2'b10) && (stage_in == 2'b00)) begin
      timeStep_d = timeStep_q + TIME_BITS'(1);
    end
  end

  // Control and status registers, all cleared by the synchronous reset.
  always_ff @(posedge clock_fast) begin
    if (reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      dataValid_q <= 1'b0;
      overflow_q  <= 1'b0;
      dropped_q   <= '0;
      timeStep_q  <= '0;
      stagePrev_q <= 2'b00;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      dataValid_q <= (count_d != '0);
      overflow_q  <= overflow_d;
      dropped_q   <= dropped_d;
      timeStep_q  <= timeStep_d;
      stagePrev_q <= stage_in;
    end
  end

  // Storage array is not reset; only slots behind valid pointers are ever read as valid data.
  always_ff @(posedge clock_fast) begin
    if (pushAcc) begin
      mem_q[wrPtr_q] <= pushWord;
    end
  end

  // Head entry falls through straight from the registered read pointer.
  always_comb begin
    data_out      = mem_q[rdPtr_q];
    data_valid    = dataValid_q;
    fifo_count    = count_q;
    overflow      = overflow_q;
    dropped_count = dropped_q;
    time_step     = timeStep_q;
  end

endmodule
